// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage: execute stage of the 5-stage pipelined CPU.
// Forwards rs1/rs2 from EX/MEM and WB, decodes ALU control, executes single-
// cycle ALU ops, runs an iterative shift-add multiplier that stalls the front
// end, and owns the EX/MEM pipeline register.
// -----------------------------------------------------------------------------
module ex_stage #(
   parameter int MUL_STEP = 1,      // multiplier bits consumed per BUSY cycle (1, 2, 4)
   parameter bit FWD_EN   = 1'b1    // 0 bypasses the forwarding muxes
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] RSdata_i,
   input  logic [31:0] RTdata_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  RDaddr_i,
   input  logic [1:0]  ALUOp_i,
   input  logic        ALUSrc_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic [31:0] WB_data_i,
   input  logic [4:0]  WB_RDaddr_i,
   input  logic        WB_RegWrite_i,
   output logic        stall_o,
   output logic [31:0] ALUres_o,
   output logic [31:0] MemWdata_o,
   output logic [4:0]  RDaddr_o,
   output logic        MemRead_o,
   output logic        MemWrite_o,
   output logic        RegWrite_o,
   output logic        MemtoReg_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ZERO} alu_op_t;

   localparam int         MUL_CYCLES = 32 / MUL_STEP;
   localparam logic [5:0] LAST_CNT   = 6'(MUL_CYCLES - 1);

   // Instruction fields
   logic [4:0] rs1, rs2;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];

   // rd and opcode fields arrive separately via RDaddr_i / ALUOp_i
   logic unused_inst_bits;
   assign unused_inst_bits = ^inst_i[11:0];

   mul_state_t state_q, state_d;
   alu_op_t    alu_op;
   logic       is_mul, mul_start;
   logic [31:0] rs1_fwd, rs2_fwd, op_b, alu_result;
   logic [31:0] mul_mcand_q, mul_mplier_q, mul_acc_q, acc_step;
   logic [5:0]  mul_cnt_q;
   logic        exmem_fwd_ok, wb_fwd_ok;

   // Forwarding muxes: EX/MEM has priority over WB; x0 and loads never forward
   // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      exmem_fwd_ok = RegWrite_o && !MemtoReg_o && (RDaddr_o != 5'd0);
      wb_fwd_ok    = WB_RegWrite_i && (WB_RDaddr_i != 5'd0);
      rs1_fwd      = RSdata_i;
      rs2_fwd      = RTdata_i;
      if (FWD_EN) begin
         if (exmem_fwd_ok && (RDaddr_o == rs1))        rs1_fwd = ALUres_o;
         else if (wb_fwd_ok && (WB_RDaddr_i == rs1))   rs1_fwd = WB_data_i;
         if (exmem_fwd_ok && (RDaddr_o == rs2))        rs2_fwd = ALUres_o;
         else if (wb_fwd_ok && (WB_RDaddr_i == rs2))   rs2_fwd = WB_data_i;
      end
   end

   assign op_b = ALUSrc_i ? imm_i : rs2_fwd;

   // ALU control decode from ALUOp / funct7 / funct3
   always_comb begin
      alu_op = OP_ZERO;
      unique case (ALUOp_i)
         2'b00: alu_op = OP_ADD;
         2'b01: alu_op = OP_SUB;
         2'b10: begin
            unique case ({funct7, funct3})
               {7'b0000000, 3'b000}: alu_op = OP_ADD;
               {7'b0100000, 3'b000}: alu_op = OP_SUB;
               {7'b0000000, 3'b111}: alu_op = OP_AND;
               {7'b0000000, 3'b110}: alu_op = OP_OR;
               {7'b0000001, 3'b000}: alu_op = OP_MUL;
               default:              alu_op = OP_ZERO;
            endcase
         end
         2'b11: alu_op = (funct3 == 3'b000) ? OP_ADD : OP_ZERO;
         default: alu_op = OP_ZERO;
      endcase
   end

   assign is_mul = (alu_op == OP_MUL);

   // ALU execute; a MUL only reaches EX/MEM from DONE, when the product is ready
   always_comb begin
      alu_result = 32'd0;
      unique case (alu_op)
         OP_ADD:  alu_result = rs1_fwd + op_b;
         OP_SUB:  alu_result = rs1_fwd - op_b;
         OP_AND:  alu_result = rs1_fwd & op_b;
         OP_OR:   alu_result = rs1_fwd | op_b;
         OP_MUL:  alu_result = mul_acc_q;
         default: alu_result = 32'd0;
      endcase
   end

   // Multiplier FSM state register
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Multiplier FSM next-state logic; DONE always returns to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (is_mul) state_d = S_BUSY;
         S_BUSY:  if (mul_cnt_q == LAST_CNT) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Multiplier FSM outputs; stall is held low during reset
   always_comb begin
      stall_o   = 1'b0;
      mul_start = 1'b0;
      if (!rst_i) begin
         unique case (state_q)
            S_IDLE: begin
               stall_o   = is_mul;
               mul_start = is_mul;
            end
            S_BUSY:  stall_o = 1'b1;
            default: stall_o = 1'b0;
         endcase
      end
   end

   // One shift-add step over MUL_STEP multiplier LSBs
   always_comb begin
      acc_step = mul_acc_q;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (mul_mplier_q[i]) acc_step = acc_step + (mul_mcand_q << i);
      end
   end

   // Step counter
   always_ff @(posedge clk_i) begin
      if (rst_i || mul_start)     mul_cnt_q <= 6'd0;
      else if (state_q == S_BUSY) mul_cnt_q <= mul_cnt_q + 6'd1;
   end

   // Multiplier datapath: capture forwarded operands at start, then shift-add
   // NOTE: no reset here on purpose; these are always loaded at start before the FSM can reach DONE and expose them.
   always_ff @(posedge clk_i) begin
      if (mul_start) begin
         mul_mcand_q  <= rs1_fwd;
         mul_mplier_q <= rs2_fwd;
         mul_acc_q    <= 32'd0;
      end else if (state_q == S_BUSY) begin
         mul_mcand_q  <= mul_mcand_q << MUL_STEP;
         mul_mplier_q <= mul_mplier_q >> MUL_STEP;
         mul_acc_q    <= acc_step;
      end
   end

   // EX/MEM pipeline register; stalled edges load a bubble
   always_ff @(posedge clk_i) begin
      if (rst_i || stall_o) begin
         ALUres_o   <= 32'd0;
         MemWdata_o <= 32'd0;
         RDaddr_o   <= 5'd0;
         MemRead_o  <= 1'b0;
         MemWrite_o <= 1'b0;
         RegWrite_o <= 1'b0;
         MemtoReg_o <= 1'b0;
      end else begin
         ALUres_o   <= alu_result;
         MemWdata_o <= rs2_fwd;
         RDaddr_o   <= RDaddr_i;
         MemRead_o  <= MemRead_i;
         MemWrite_o <= MemWrite_i;
         RegWrite_o <= RegWrite_i;
         MemtoReg_o <= MemtoReg_i;
      end
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage pipelined CPU. It sits directly downstream of the ID/EX pipeline register and consumes all of its outputs. It performs operand forwarding, ALU control decode and ALU execution, plus an iterative multiplier that stalls the front end. It also owns the EX/MEM pipeline register that feeds the data-memory stage. Branches are resolved in ID and are not handled here.

Parameters:
MUL_STEP, 1, multiplier bits consumed per BUSY cycle (legal values 1, 2, 4); BUSY lasts 32/MUL_STEP cycles.
FWD_EN, 1, 1 enables the forwarding muxes; 0 always uses RSdata_i/RTdata_i.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
inst_i  in  32  instruction from ID/EX; rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25]
RSdata_i  in  32  rs1 register value from ID/EX
RTdata_i  in  32  rs2 register value from ID/EX
imm_i  in  32  sign-extended immediate from ID/EX
RDaddr_i  in  5  destination register from ID/EX
ALUOp_i  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode
ALUSrc_i  in  1  1 selects imm_i as operand B
MemRead_i / MemWrite_i / RegWrite_i / MemtoReg_i  in  1 each  control bits from ID/EX
WB_data_i  in  32  write-back data
WB_RDaddr_i  in  5  write-back destination
WB_RegWrite_i  in  1  write-back enable
stall_o  out  1  hold PC, IF/ID and ID/EX this cycle
ALUres_o  out  32  EX/MEM result or address
MemWdata_o  out  32  EX/MEM store data
RDaddr_o  out  5  EX/MEM destination
MemRead_o / MemWrite_o / RegWrite_o / MemtoReg_o  out  1 each  EX/MEM control bits

Behaviour:
- Reset:
  - All EX/MEM outputs are 0.
  - FSM goes to IDLE and the multiplier counter is cleared.
  - stall_o is forced to 0 while rst_i=1.
  - Reset mid-multiply aborts the operation; no result is written.
- Forwarding (FWD_EN=1), evaluated independently for rs1 and rs2:
  - Priority 1, EX/MEM: RegWrite_o=1, MemtoReg_o=0, RDaddr_o!=0 and RDaddr_o==rsX. Value is ALUres_o.
  - Priority 2, WB: WB_RegWrite_i=1, WB_RDaddr_i!=0 and WB_RDaddr_i==rsX. Value is WB_data_i.
  - Otherwise the register-file value is used.
  - Load-use hazards are the hazard unit's job; this block never forwards load data.
- Operand B is imm_i when ALUSrc_i=1, else forwarded rs2. MemWdata_o always takes forwarded rs2.
- ALU decode:
  - ALUOp=00: add. ALUOp=01: sub.
  - ALUOp=10 by funct7/funct3: 0000000/000 add, 0100000/000 sub, 0000000/111 and, 0000000/110 or, 0000001/000 mul. Any other code gives result 0.
  - ALUOp=11: funct3=000 addi; otherwise 0.
  - All arithmetic is 32-bit wrap-around; no overflow flag.
- Single-cycle ops: EX/MEM latches the result and control bits at the next edge. Latency is 1 cycle.
- MUL FSM:
  - IDLE: a MUL decode raises stall_o combinationally. At the edge, forwarded operands are captured into internal registers (ID/EX holds during stall, but forwarding sources change). Acc and counter are cleared; next state is BUSY.
  - BUSY: stall_o=1. Each cycle processes MUL_STEP multiplier LSBs (shift-add, low 32 bits kept). After 32/MUL_STEP cycles, next state is DONE.
  - DONE: stall_o=0. At the edge, EX/MEM latches the product with the MUL's control bits and RDaddr; next state is IDLE. A MUL visible in DONE never restarts.
  - stall_o is high for 1+32/MUL_STEP cycles; the EX/MEM result appears 2+32/MUL_STEP edges after the MUL enters EX.
- Bubbles: every edge with stall_o=1 loads EX/MEM with a bubble: all control bits 0, RDaddr_o=0, ALUres_o=0, MemWdata_o=0.
- Back-to-back MULs: the second MUL enters EX after DONE and starts from IDLE normally.
- RDaddr 0: results still flow, but forwarding ignores x0.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with add x1 valid on inputs -> all outputs 0, stall_o=0; first post-reset edge latches add result.
- addi x5,x0,7 then add x6,x5,x5 (RSdata stale=0) -> cycle 2 ALUres_o=14 via EX/MEM forward; with the same producer only in WB (WB_data_i=7) -> 14 via WB.
- Priority: EX/MEM holds x3=10 and WB holds x3=20; sub x4,x3,x0 -> ALUres_o=10.
- mul x7,x8,x9 with 0x0001_0003 × 0x0000_0005, MUL_STEP=1 -> stall_o high 33 cycles, bubbles in EX/MEM, then ALUres_o=0x0005_000F, RegWrite_o=1, RDaddr_o=7; repeat with 0xFFFF_FFFF × 0xFFFF_FFFF -> 0x0000_0001.
- sw with forwarded rs2=0xDEAD_BEEF, imm_i=8, rs1=0x100 -> ALUres_o=0x108, MemWdata_o=0xDEAD_BEEF, MemWrite_o=1.
- Assert rst_i during BUSY cycle 10 -> next cycle stall_o=0, EX/MEM all 0; re-presented MUL completes with the correct product.
